// File: rtl/pe_conv_sequencer.sv
// Control sequencer for one PE's 1-D convolution: MAC walk over ifmap/filter pads
// into the psum pad, then drain of finished psums into the PE output FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; all outputs low
// WAIT_SRC | job accepted, waiting for ifmap and filter pads to be loaded
// MAC      | one filter tap per cycle, psum accumulated in place
// DRAIN    | move OUT_LEN psums from psum pad to output FIFO, with backpressure
// DONE     | one-cycle done pulse, psum pad pointers cleared
module pe_conv_sequencer #(
    parameter int IFMAP_LEN = 8,
    parameter int FILT_LEN  = 3,
    parameter int STRIDE    = 1,
    localparam int OUT_LEN  = (IFMAP_LEN - FILT_LEN) / STRIDE + 1,
    localparam int IF_AW    = (IFMAP_LEN > 1) ? $clog2(IFMAP_LEN) : 1,
    localparam int FW_AW    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             if_ready,
    input  logic             fw_ready,
    output logic [IF_AW-1:0] if_raddr,
    output logic [FW_AW-1:0] fw_raddr,
    output logic             mac_en,
    output logic             acc_zero,
    output logic             psum_wen,
    output logic             psum_ren,
    output logic             psum_freeze,
    output logic             psum_same_addr,
    output logic             psum_clear,
    input  logic             psum_full,
    input  logic             psum_empty,
    input  logic             out_full,
    output logic             out_wen,
    output logic             busy,
    output logic             done
);

    localparam int OC_W = $clog2(OUT_LEN + 1);
    localparam int K_W  = $clog2(FILT_LEN + 1);
    localparam logic [OC_W-1:0] O_LAST = OC_W'(OUT_LEN - 1);
    localparam logic [K_W-1:0]  K_LAST = K_W'(FILT_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SRC,
        MAC,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    logic [OC_W-1:0] o_cnt;
    logic [K_W-1:0]  k_cnt;
    logic [OC_W-1:0] d_cnt;
    logic            err_ovf;
    logic            xfer;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            o_cnt   <= '0;
            k_cnt   <= '0;
            d_cnt   <= '0;
            err_ovf <= 1'b0;
        end else begin
            // writing into a full psum pad is a setup error; keep running, remember it
            err_ovf <= err_ovf | (psum_wen & psum_full);
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= WAIT_SRC;
                        o_cnt <= '0;
                        k_cnt <= '0;
                        d_cnt <= '0;
                    end
                end
                WAIT_SRC: begin
                    if (if_ready && fw_ready) state <= MAC;
                end
                MAC: begin
                    if (k_cnt == K_LAST) begin
                        k_cnt <= '0;
                        if (o_cnt == O_LAST) begin
                            o_cnt <= '0;
                            state <= DRAIN;
                        end else begin
                            o_cnt <= o_cnt + 1'b1;
                        end
                    end else begin
                        k_cnt <= k_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        if (d_cnt == O_LAST) begin
                            d_cnt <= '0;
                            state <= DONE;
                        end else begin
                            d_cnt <= d_cnt + 1'b1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; drain handshake also gates on pad/FIFO flags.
    always_comb begin
        xfer           = (state == DRAIN) && !psum_empty && !out_full;
        if_raddr       = '0;
        fw_raddr       = '0;
        mac_en         = 1'b0;
        acc_zero       = 1'b0;
        psum_wen       = 1'b0;
        psum_ren       = 1'b0;
        psum_freeze    = 1'b0;
        psum_same_addr = 1'b0;
        psum_clear     = 1'b0;
        out_wen        = 1'b0;
        done           = 1'b0;
        busy           = (state != IDLE);
        case (state)
            MAC: begin
                if_raddr       = IF_AW'(32'(o_cnt) * STRIDE + 32'(k_cnt));
                fw_raddr       = FW_AW'(k_cnt);
                mac_en         = 1'b1;
                acc_zero       = (k_cnt == '0);
                psum_wen       = 1'b1;
                psum_same_addr = 1'b1;
                psum_freeze    = (k_cnt != K_LAST);
            end
            DRAIN: begin
                psum_ren = xfer;
                out_wen  = xfer;
            end
            DONE: begin
                done       = 1'b1;
                psum_clear = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
